// File: rtl/issue_scheduler.sv
// issue_scheduler: one-deep hold register with scoreboard hazard check, per-unit credit limits and SYNC drain barrier.
module issue_scheduler #(
  parameter int NUM_REGS        = 16,
  parameter int REG_W           = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PERF_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_opcode,
  input  logic [REG_W-1:0]      in_rd,
  input  logic [REG_W-1:0]      in_rs1,
  input  logic [REG_W-1:0]      in_rs2,
  input  logic [15:0]           in_imm,
  input  logic                  in_is_matrix,
  input  logic                  in_uses_dma,
  input  logic                  in_needs_sync,
  output logic                  alu_valid,
  output logic                  mat_valid,
  output logic                  dma_valid,
  input  logic                  alu_ready,
  input  logic                  mat_ready,
  input  logic                  dma_ready,
  output logic [3:0]            iss_opcode,
  output logic [REG_W-1:0]      iss_rd,
  output logic [REG_W-1:0]      iss_rs1,
  output logic [REG_W-1:0]      iss_rs2,
  output logic [15:0]           iss_imm,
  input  logic [2:0]            cmp_valid,
  input  logic [3*REG_W-1:0]    cmp_rd,
  output logic                  sync_done,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  idle,
  output logic [PERF_W-1:0]     stall_cycles,
  output logic                  err_underflow
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [1:0] U_ALU = 2'd0, U_MAT = 2'd1, U_DMA = 2'd2, U_SYNC = 2'd3;
  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_SYNC} state_t;
  state_t state_q, state_d;
  logic [1:0] route_q, route_d;
  logic [3:0] opcode_q, opcode_d;
  logic [REG_W-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [15:0] imm_q, imm_d;
  logic [NUM_REGS-1:0] busy_q, busy_d, set_v, clr_v;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [PERF_W-1:0] stall_q, stall_d;
  logic err_q, err_d;
  logic [2:0] lim, vld, fire_u;
  logic hazard, cnt_zero, fire, acc;
  always_comb begin
    hazard = busy_q[rs1_q] || busy_q[rs2_q] || (route_q != U_DMA && busy_q[rd_q]);
    for (int u = 0; u < 3; u++) lim[u] = cnt_q[u] < CNT_W'(MAX_OUTSTANDING);
    cnt_zero = cnt_q[0] == '0 && cnt_q[1] == '0 && cnt_q[2] == '0;
    vld = (state_q == S_HOLD && !hazard) ? (3'b001 << route_q) & lim : 3'b000;
    fire_u = vld & {dma_ready, mat_ready, alu_ready};
    sync_done = state_q == S_SYNC && cnt_zero && busy_q == '0;
    fire = |fire_u || sync_done;
    in_ready = state_q == S_EMPTY || fire;
    acc = in_valid && in_ready;
    state_d = acc ? (in_needs_sync ? S_SYNC : S_HOLD) : fire ? S_EMPTY : state_q;
    route_d = acc ? (in_needs_sync ? U_SYNC : in_uses_dma ? U_DMA : in_is_matrix ? U_MAT : U_ALU) : route_q;
    opcode_d = acc ? in_opcode : opcode_q;
    rd_d = acc ? in_rd : rd_q;
    rs1_d = acc ? in_rs1 : rs1_q;
    rs2_d = acc ? in_rs2 : rs2_q;
    imm_d = acc ? in_imm : imm_q;
    // set is applied after clear so a same-cycle reissue of a register keeps it busy
    set_v = '0;
    clr_v = '0;
    if (fire_u[0] || fire_u[1]) set_v[rd_q] = 1'b1;
    for (int u = 0; u < 2; u++) if (cmp_valid[u]) clr_v[cmp_rd[u*REG_W +: REG_W]] = 1'b1;
    busy_d = ((busy_q & ~clr_v) | set_v) & ~NUM_REGS'(1);
    err_d = err_q;
    for (int u = 0; u < 3; u++) begin
      cnt_d[u] = cnt_q[u] + CNT_W'(fire_u[u]) - CNT_W'(cmp_valid[u] && cnt_q[u] != '0);
      if (cmp_valid[u] && cnt_q[u] == '0) err_d = 1'b1;
    end
    stall_d = (state_q != S_EMPTY && !fire && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      route_q <= U_ALU;
      opcode_q <= '0;
      rd_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      busy_q <= '0;
      cnt_q <= '{default: '0};
      stall_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      opcode_q <= opcode_d;
      rd_q <= rd_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      imm_q <= imm_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      stall_q <= stall_d;
      err_q <= err_d;
    end
  end
  assign {dma_valid, mat_valid, alu_valid} = vld;
  assign iss_opcode = opcode_q;
  assign iss_rd = rd_q;
  assign iss_rs1 = rs1_q;
  assign iss_rs2 = rs2_q;
  assign iss_imm = imm_q;
  assign busy_vec = busy_q;
  assign idle = state_q == S_EMPTY && cnt_zero;
  assign stall_cycles = stall_q;
  assign err_underflow = err_q;
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed vectors for issue_scheduler with hand-computed expectations.
module tb_issue_scheduler;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [3:0] in_opcode = '0;
  logic [3:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [15:0] in_imm = '0;
  logic in_is_matrix = 1'b0, in_uses_dma = 1'b0, in_needs_sync = 1'b0;
  logic alu_valid, mat_valid, dma_valid;
  logic alu_ready = 1'b1, mat_ready = 1'b1, dma_ready = 1'b1;
  logic [3:0] iss_opcode, iss_rd, iss_rs1, iss_rs2;
  logic [15:0] iss_imm;
  logic [2:0] cmp_valid = '0;
  logic [11:0] cmp_rd = '0;
  logic sync_done, idle, err_underflow;
  logic [15:0] busy_vec, stall_cycles;
  int errors = 0, checks = 0;

  issue_scheduler dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_is_matrix(in_is_matrix), .in_uses_dma(in_uses_dma), .in_needs_sync(in_needs_sync),
    .alu_valid(alu_valid), .mat_valid(mat_valid), .dma_valid(dma_valid),
    .alu_ready(alu_ready), .mat_ready(mat_ready), .dma_ready(dma_ready),
    .iss_opcode(iss_opcode), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_imm(iss_imm),
    .cmp_valid(cmp_valid), .cmp_rd(cmp_rd), .sync_done(sync_done), .busy_vec(busy_vec),
    .idle(idle), .stall_cycles(stall_cycles), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nb;
    @(negedge clk);
  endtask

  task automatic drv(input logic sync, input logic dma, input logic mat, input logic [3:0] op,
                     input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2, input logic [15:0] imm);
    in_valid = 1'b1;
    in_needs_sync = sync;
    in_uses_dma = dma;
    in_is_matrix = mat;
    in_opcode = op;
    in_rd = rd;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_imm = imm;
  endtask

  initial begin
    nb;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_valids", {dma_valid, mat_valid, alu_valid}, 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_sync_done", sync_done, 0);
    chk("rst_payload", {iss_opcode, iss_rd, iss_imm}, 0);
    rst_n = 1'b1;
    nb;
    // independent stream: ALU r1<-r2,r3 ; MAT r4 ; DMA
    drv(0, 0, 0, 4'd1, 4'd1, 4'd2, 4'd3, 16'h0001);
    nb;
    chk("ind_alu_valid", alu_valid, 1);
    chk("ind_alu_rd", iss_rd, 1);
    drv(0, 0, 1, 4'd2, 4'd4, 4'd0, 4'd0, 16'h0002);
    nb;
    chk("ind_mat_only", {dma_valid, mat_valid, alu_valid}, 3'b010);
    drv(0, 1, 0, 4'd3, 4'd7, 4'd0, 4'd0, 16'h0010);
    nb;
    chk("ind_dma_only", {dma_valid, mat_valid, alu_valid}, 3'b100);
    in_valid = 1'b0;
    nb;
    chk("ind_busy", busy_vec, 16'h0012);
    chk("ind_stall", stall_cycles, 0);
    chk("ind_not_idle", idle, 0);
    cmp_valid = 3'b111;
    cmp_rd = {4'd0, 4'd4, 4'd1};
    nb;
    cmp_valid = '0;
    chk("ind_cleared", busy_vec, 0);
    chk("ind_idle", idle, 1);
    // RAW hazard
    drv(0, 0, 0, 4'd1, 4'd5, 4'd1, 4'd2, 16'h0000);
    nb;
    chk("raw_first", alu_valid, 1);
    drv(0, 0, 0, 4'd1, 4'd6, 4'd5, 4'd0, 16'h0000);
    nb;
    chk("raw_blocked0", alu_valid, 0);
    chk("raw_in_ready", in_ready, 0);
    in_valid = 1'b0;
    nb;
    chk("raw_blocked1", alu_valid, 0);
    nb;
    chk("raw_blocked2", alu_valid, 0);
    nb;
    chk("raw_blocked3", alu_valid, 0);
    cmp_valid = 3'b001;
    cmp_rd = 12'h005;
    nb;
    cmp_valid = '0;
    chk("raw_released", alu_valid, 1);
    chk("raw_rd", iss_rd, 6);
    chk("raw_busy_mid", busy_vec, 0);
    nb;
    chk("raw_stall", stall_cycles, 4);
    chk("raw_busy", busy_vec, 16'h0040);
    cmp_valid = 3'b001;
    cmp_rd = 12'h006;
    nb;
    cmp_valid = '0;
    // counter limit: five DMA
    drv(0, 1, 0, 4'd3, 4'd0, 4'd0, 4'd0, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      nb;
      chk("lim_dma_fire", dma_valid, 1);
    end
    nb;
    chk("lim_blocked", dma_valid, 0);
    chk("lim_in_ready", in_ready, 0);
    in_valid = 1'b0;
    nb;
    chk("lim_still_blocked", dma_valid, 0);
    cmp_valid = 3'b100;
    nb;
    cmp_valid = '0;
    chk("lim_fifth", dma_valid, 1);
    nb;
    chk("lim_done", dma_valid, 0);
    chk("lim_stall", stall_cycles, 6);
    chk("lim_busy", busy_vec, 0);
    cmp_valid = 3'b100;
    repeat (4) nb;
    cmp_valid = '0;
    chk("lim_idle", idle, 1);
    // SYNC barrier
    drv(0, 0, 1, 4'd2, 4'd8, 4'd0, 4'd0, 16'h0000);
    nb;
    chk("sync_mat1", mat_valid, 1);
    drv(0, 0, 1, 4'd2, 4'd9, 4'd0, 4'd0, 16'h0000);
    nb;
    chk("sync_mat2", mat_valid, 1);
    drv(1, 0, 0, 4'd15, 4'd0, 4'd0, 4'd0, 16'h0000);
    nb;
    in_valid = 1'b0;
    in_needs_sync = 1'b0;
    chk("sync_wait_in_ready", in_ready, 0);
    chk("sync_busy", busy_vec, 16'h0300);
    cmp_valid = 3'b010;
    cmp_rd = 12'h080;
    nb;
    cmp_valid = '0;
    chk("sync_pending", sync_done, 0);
    for (int i = 0; i < 9; i++) begin
      nb;
      chk("sync_no_valid", {sync_done, dma_valid, mat_valid, alu_valid}, 0);
    end
    cmp_valid = 3'b010;
    cmp_rd = 12'h090;
    nb;
    cmp_valid = '0;
    chk("sync_done_pulse", sync_done, 1);
    chk("sync_done_ready", in_ready, 1);
    chk("sync_done_valids", {dma_valid, mat_valid, alu_valid}, 0);
    nb;
    chk("sync_done_low", sync_done, 0);
    chk("sync_idle", idle, 1);
    chk("sync_stall", stall_cycles, 17);
    // unit back-pressure
    mat_ready = 1'b0;
    drv(0, 0, 1, 4'd5, 4'd10, 4'd0, 4'd0, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      nb;
      in_valid = 1'b0;
      in_is_matrix = 1'b0;
      chk("bp_valid", mat_valid, 1);
      chk("bp_payload", {iss_opcode, iss_rd, iss_imm}, {4'd5, 4'd10, 16'h1234});
    end
    mat_ready = 1'b1;
    nb;
    chk("bp_fired", mat_valid, 0);
    chk("bp_stall", stall_cycles, 19);
    chk("bp_busy", busy_vec, 16'h0400);
    cmp_valid = 3'b010;
    cmp_rd = 12'h0A0;
    nb;
    cmp_valid = '0;
    // underflow
    cmp_valid = 3'b001;
    cmp_rd = 12'h000;
    nb;
    cmp_valid = '0;
    chk("uf_err", err_underflow, 1);
    chk("uf_idle", idle, 1);
    nb;
    chk("uf_sticky", err_underflow, 1);
    // async reset while holding
    alu_ready = 1'b0;
    drv(0, 0, 0, 4'd1, 4'd3, 4'd0, 4'd0, 16'h00AA);
    nb;
    in_valid = 1'b0;
    chk("rr_held", alu_valid, 1);
    chk("rr_not_idle", idle, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_valid", alu_valid, 0);
    chk("rr_idle", idle, 1);
    chk("rr_in_ready", in_ready, 1);
    chk("rr_stall", stall_cycles, 0);
    chk("rr_err", err_underflow, 0);
    chk("rr_payload", {iss_opcode, iss_rd, iss_imm}, 0);
    nb;
    rst_n = 1'b1;
    alu_ready = 1'b1;
    cmp_valid = 3'b001;
    cmp_rd = 12'h003;
    nb;
    cmp_valid = '0;
    chk("rr_late_cmp_err", err_underflow, 1);
    chk("rr_late_idle", idle, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Sits between the instruction decode stage and the execution units (scalar ALU, matrix engine, DMA engine).
- Holds one decoded instruction and resolves register hazards through a 16-entry scoreboard.
- Routes the instruction to exactly one unit over valid/ready, tracks outstanding operations per unit, and implements SYNC as a full drain barrier.

Parameters:
- NUM_REGS, 16, architectural registers tracked by the scoreboard.
- REG_W, 4, register index width.
- MAX_OUTSTANDING, 4, per-unit limit on in-flight operations.
- PERF_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  scheduler can accept an instruction
- in_opcode  in  4  opcode
- in_rd / in_rs1 / in_rs2  in  REG_W each  destination and sources
- in_imm  in  16  immediate/offset
- in_is_matrix / in_uses_dma / in_needs_sync  in  1 each  decoded class flags
- alu_valid, mat_valid, dma_valid  out  1 each  dispatch valid per unit
- alu_ready, mat_ready, dma_ready  in  1 each  unit accepts
- iss_opcode, iss_rd, iss_rs1, iss_rs2, iss_imm  out  4/REG_W/REG_W/REG_W/16  shared dispatch payload
- cmp_valid  in  3  completion pulse: [0] ALU, [1] MAT, [2] DMA
- cmp_rd  in  3*REG_W  completing destination per unit, same bit order
- sync_done  out  1  one-cycle pulse when SYNC retires
- busy_vec  out  NUM_REGS  scoreboard state
- idle  out  1  no held instruction and all counters zero
- stall_cycles  out  PERF_W  saturating stall counter
- err_underflow  out  1  sticky: completion seen with that unit's counter at 0

Behaviour:
- Reset values:
  - All valids 0, sync_done 0, busy_vec 0, counters 0, stall_cycles 0, err_underflow 0, payload 0.
  - in_ready is 1 and idle is 1.
- Hold register:
  - in_ready = !hold_valid || fire.
  - On in_valid && in_ready, the instruction is latched. Earliest dispatch is the next cycle, so latency is 1.
  - Back-to-back independent instructions sustain one issue per cycle.
- Routing priority: needs_sync → SYNC; else uses_dma → DMA; else is_matrix → MAT; else ALU.
- Dispatch condition for non-SYNC: hold_valid, target counter < MAX_OUTSTANDING, and no hazard.
  - Hazard: busy[rs1], busy[rs2], or busy[rd] (WAW) for ALU/MAT.
  - Hazard: busy[rs1] or busy[rs2] for DMA.
  - Register 0 never counts as busy.
- The hazard check uses the registered busy_vec only; there is no same-cycle completion bypass, so clearing a dependency costs a 1-cycle bubble.
- Exactly one unit valid is asserted at a time. Once asserted, valid and payload stay stable until ready (conditions can only relax).
- fire = unit valid && unit ready. On fire:
  - hold is cleared.
  - The unit counter increments.
  - For ALU/MAT with rd != 0, busy[rd] is set.
  - DMA does not set busy.
- Completion: cmp_valid[u] decrements counter u and, for ALU/MAT, clears busy[cmp_rd[u]].
  - Increment and decrement in the same cycle leave the counter unchanged.
  - Decrement at 0 is ignored and sets err_underflow.
- Busy set and clear on the same register in the same cycle: set wins.
- FSM states:
  - EMPTY → HOLD on accept of a non-SYNC instruction.
  - EMPTY → SYNC_WAIT on accept of a SYNC instruction.
  - HOLD → EMPTY on fire, or stays in HOLD/SYNC_WAIT when a new instruction is accepted the same cycle.
  - SYNC_WAIT → EMPTY when all counters are 0 and busy_vec is 0. sync_done pulses that cycle and in_ready is 1 that cycle.
- SYNC issues no unit valid. A SYNC arriving when already drained retires the cycle after acceptance.
- stall_cycles increments every cycle with hold_valid && !fire (SYNC_WAIT included) and saturates at all-ones.
- Asynchronous reset mid-operation discards the held instruction, counters and scoreboard immediately. Completions arriving after reset trigger err_underflow.

Test Plan:
- Independent instruction stream: ALU r1←r2,r3, then MAT r4, then DMA, with all ready=1 → one valid per cycle starting 1 cycle after accept; busy_vec=0x0012; stall_cycles=0.
- RAW hazard: ALU r5←r1,r2, then ALU r6←r5,r0, with cmp_valid[0] and cmp_rd=5 three cycles later → second alu_valid rises exactly 1 cycle after the completion; stall_cycles=4.
- Counter limit: 5 DMA issues with no completions → dma_valid held low after the 4th fire, in_ready=0; one cmp_valid[2] → 5th fires next cycle.
- SYNC barrier: 2 MAT ops outstanding, then SYNC, then complete both 10 cycles apart → sync_done pulses the cycle both counters reach 0 and busy_vec=0; no unit valid is asserted during SYNC.
- Stall: mat_ready=0 for 3 cycles → mat_valid and payload are stable for all 3 cycles.
- Underflow: cmp_valid[0] with no outstanding ALU op → err_underflow=1 and stays 1; counter stays 0.
- Reset mid-operation: assert rst_n=0 while in HOLD → all outputs return to reset values asynchronously, idle=1.
